// File: rtl/ifetch_prefetch.sv
// Instruction prefetch unit: fetches sequential words from instruction
// memory into a small FIFO toward decode, with one memory transaction in
// flight at most and redirect (branch/jump) support that flushes the queue
// and squashes any response still owed by memory.
module ifetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RESP    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          kill_q, kill_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   instr_d [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   pc_d    [DEPTH];

  logic          push;
  logic          pop;

  // External view: request comes straight from state, head entry gated by valid
  always_comb begin
    mem_req   = (state_q == REQ);
    mem_addr  = addr_q;
    out_valid = (count_q != '0);
    out_instr = out_valid ? instr_q[rd_ptr_q] : '0;
    out_pc    = out_valid ? pc_q[rd_ptr_q] : '0;
    pop       = out_valid && out_ready && !redirect_valid;
  end

  // Fetch FSM: next state, request address, fetch pointer and push decision
  // A redirect seen while waiting for gnt cannot retract the request, so it
  // is remembered in kill_q and the granted transaction is turned into a
  // DISCARD without advancing fetch_pc past the redirect target.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    kill_d     = kill_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!redirect_valid && (count_q < FULL)) begin
          state_d = REQ;
          addr_d  = fetch_pc_q;
          kill_d  = 1'b0;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          kill_d = 1'b0;
          if (kill_q || redirect_valid) begin
            state_d = DISCARD;
          end else begin
            state_d    = RESP;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          push    = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & WORD_MASK;
    end
  end

  // FIFO bookkeeping: redirect flushes and overrides any same-cycle push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = mem_rdata;
        pc_d[wr_ptr_q]    = addr_q;
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State and FIFO registers, asynchronously cleared
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC & WORD_MASK;
      addr_q     <= '0;
      kill_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      kill_q     <= kill_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: reset, streaming across the address
// wrap, backpressure, redirect in RESP and in REQ, async reset mid-fetch.
module tb_ifetch_prefetch;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  bit          auto_mem   = 1'b0;
  bit          chk_stream = 1'b0;
  bit          pend       = 1'b0;
  logic [31:0] pend_addr  = '0;
  logic [31:0] exp_pc     = '0;
  int          n_pop      = 0;
  logic [31:0] gnt_q [$];

  ifetch_prefetch #(
    .DEPTH   (4),
    .RESET_PC(32'hFFFF_FFFC)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: optional auto memory responder and stream checking, then
  // advance to 1 time unit after the rising edge.
  task automatic cycle();
    bit          g;
    logic [31:0] a;
    if (auto_mem) begin
      mem_gnt    = 1'b1;
      mem_rvalid = pend;
      mem_rdata  = pend ? mem_word(pend_addr) : '0;
    end
    #0;
    if (chk_stream && out_valid && out_ready) begin
      check("stream_pc", out_pc, exp_pc);
      check("stream_instr", out_instr, mem_word(exp_pc));
      exp_pc += 32'd4;
      n_pop++;
    end
    g = mem_req && mem_gnt;
    a = mem_addr;
    if (g) gnt_q.push_back(a);
    @(posedge clk);
    #1;
    if (auto_mem) begin
      pend      = g;
      pend_addr = a;
    end
  endtask

  initial begin
    n_rst          = 1'b0;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);

    // First request on the first edge after release
    n_rst = 1'b1;
    cycle();
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, 32'hFFFF_FFFC);

    // Streaming across the wrap from 0xFFFF_FFFC to 0
    auto_mem   = 1'b1;
    out_ready  = 1'b1;
    exp_pc     = 32'hFFFF_FFFC;
    n_pop      = 0;
    chk_stream = 1'b1;
    repeat (40) cycle();
    check("stream_pops", 32'(n_pop >= 10), 32'd1);

    // Backpressure: redirect to 0, decode stalled
    chk_stream     = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    cycle();
    redirect_valid = 1'b0;
    gnt_q.delete();
    repeat (30) cycle();
    check("bp_gnt_count", 32'(gnt_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = (i < gnt_q.size()) ? gnt_q[i] : 32'hDEAD_BEEF;
      check("bp_gnt_addr", v, 32'(i * 4));
    end
    check("bp_no_req", 32'(mem_req), 32'd0);
    check("bp_head_pc", out_pc, 32'h0);
    check("bp_head_instr", out_instr, mem_word(32'h0));

    // Resume: drain 0x0..0xC, next fetch at 0x10
    gnt_q.delete();
    exp_pc     = 32'h0;
    n_pop      = 0;
    out_ready  = 1'b1;
    chk_stream = 1'b1;
    repeat (30) cycle();
    check("resume_pops", 32'(n_pop >= 6), 32'd1);
    check("resume_first_gnt", (gnt_q.size() > 0) ? gnt_q[0] : 32'hDEAD_BEEF, 32'h10);

    // Redirect in RESP: quiesce at address 0x8 first
    chk_stream     = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    cycle();
    redirect_valid = 1'b0;
    auto_mem       = 1'b0;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b1;
    mem_rdata      = 32'h1111_1111;
    cycle();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 6 && !mem_req; i++) cycle();
    check("c_req_seen", 32'(mem_req), 32'd1);
    check("c_req_addr", mem_addr, 32'h8);
    mem_gnt = 1'b1;
    cycle();
    mem_gnt        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    check("c_discard_noreq", 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = mem_word(32'h8);
    cycle();
    mem_rvalid = 1'b0;
    check("c_dropped_empty", 32'(out_valid), 32'd0);
    cycle();
    check("c_new_req", 32'(mem_req), 32'd1);
    check("c_new_addr", mem_addr, 32'h100);
    mem_gnt = 1'b1;
    cycle();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = mem_word(32'h100);
    cycle();
    mem_rvalid = 1'b0;
    check("c_out_valid", 32'(out_valid), 32'd1);
    check("c_out_pc", out_pc, 32'h100);
    check("c_out_instr", out_instr, mem_word(32'h100));

    // Redirect in REQ with gnt held low for 3 cycles
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("d_req", 32'(mem_req), 32'd1);
    check("d_req_addr", mem_addr, 32'h104);
    check("d_popped", 32'(out_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    cycle();
    redirect_valid = 1'b0;
    check("d_hold1_req", 32'(mem_req), 32'd1);
    check("d_hold1_addr", mem_addr, 32'h104);
    cycle();
    check("d_hold2_addr", mem_addr, 32'h104);
    cycle();
    check("d_hold3_req", 32'(mem_req), 32'd1);
    check("d_hold3_addr", mem_addr, 32'h104);
    mem_gnt = 1'b1;
    cycle();
    mem_gnt = 1'b0;
    check("d_discard_noreq", 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = mem_word(32'h104);
    cycle();
    mem_rvalid = 1'b0;
    check("d_dropped_empty", 32'(out_valid), 32'd0);
    cycle();
    check("d_new_req", 32'(mem_req), 32'd1);
    check("d_new_addr", mem_addr, 32'h200);
    mem_gnt = 1'b1;
    cycle();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = mem_word(32'h200);
    cycle();
    mem_rvalid = 1'b0;
    check("d_out_pc", out_pc, 32'h200);
    check("d_out_instr", out_instr, mem_word(32'h200));

    // Async reset while in RESP
    cycle();
    check("e_req_addr", mem_addr, 32'h204);
    mem_gnt = 1'b1;
    cycle();
    mem_gnt = 1'b0;
    n_rst   = 1'b0;
    #1;
    check("e_rst_mem_req", 32'(mem_req), 32'd0);
    check("e_rst_mem_addr", mem_addr, 32'd0);
    check("e_rst_out_valid", 32'(out_valid), 32'd0);
    check("e_rst_out_instr", out_instr, 32'd0);
    check("e_rst_out_pc", out_pc, 32'd0);
    @(posedge clk);
    #1;
    n_rst      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = mem_word(32'h204);
    cycle();
    mem_rvalid = 1'b0;
    check("e_first_req", 32'(mem_req), 32'd1);
    check("e_first_addr", mem_addr, 32'hFFFF_FFFC);
    check("e_late_rvalid_ignored", 32'(out_valid), 32'd0);
    cycle();
    check("e_still_empty", 32'(out_valid), 32'd0);
    check("e_still_req", 32'(mem_req), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
